// File: rtl/blk_addr_pkg.sv
// Shared constants for the turbo-block address scheduler: supported m_len
// values with their link-ID base addresses, FSM encoding and default widths.
package blk_addr_pkg;

    localparam int LEN_W_DEF   = 13;
    localparam int ADDRESS_DEF = 16;

    localparam logic [15:0] M_LEN_0 = 16'h0120;
    localparam logic [15:0] M_LEN_1 = 16'h02a0;
    localparam logic [15:0] M_LEN_2 = 16'h0420;
    localparam logic [15:0] M_LEN_3 = 16'h01b0;
    localparam logic [15:0] M_LEN_4 = 16'h0750;

    localparam logic [15:0] BASE_0 = 16'h0000;
    localparam logic [15:0] BASE_1 = 16'h0120;
    localparam logic [15:0] BASE_2 = 16'h03c0;
    localparam logic [15:0] BASE_3 = 16'h07e0;
    localparam logic [15:0] BASE_4 = 16'h0990;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/blk_addr_sched_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant, its index and a hit flag.
module rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [1:0]         idx,
    output logic               any
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    always_comb begin
        int cand;
        logic [IW-1:0] ci;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        ci     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            ci = IW'(cand);
            if (!any && req[ci]) begin
                onehot[ci] = 1'b1;
                idx        = 2'(cand);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blk_addr_sched.sv
// Turbo-block address sweep scheduler: round-robin grant, m_len decode, one
// contiguous sweep per grant. BLK_ADDR_SCHED_STALL_EN adds addr_rdy backpressure.
module blk_addr_sched
    import blk_addr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDRESS = ADDRESS_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int GAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
`ifdef BLK_ADDR_SCHED_STALL_EN
    input  logic                     addr_rdy,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     err,
    output logic [ADDRESS-1:0]       addr,
    output logic                     addr_vld,
    output logic                     addr_first,
    output logic                     addr_last,
    output logic [1:0]               owner,
    output logic                     busy
);
    // Unsupported grants always spend at least one cycle in GAP so the
    // requester can drop req before arbitration resumes.
    localparam logic [1:0] GAP_LD = (GAP > 1) ? 2'(GAP - 1) : 2'd0;

    sched_state_t state, state_nxt;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [1:0]         arb_idx;
    logic               arb_any;
    logic [1:0]         ptr;
    logic [LEN_W-1:0]   len_q, cnt, sel_len;
    logic [ADDRESS-1:0] base_q, sel_base;
    logic               sel_ok;
    logic [1:0]         gap_cnt;
    logic               at_last, advance;

    rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_onehot[i]) sel_len = req_len[i*LEN_W +: LEN_W];
    end

    always_comb begin
        sel_ok   = 1'b1;
        sel_base = '0;
        case (sel_len)
            LEN_W'(M_LEN_0): sel_base = ADDRESS'(BASE_0);
            LEN_W'(M_LEN_1): sel_base = ADDRESS'(BASE_1);
            LEN_W'(M_LEN_2): sel_base = ADDRESS'(BASE_2);
            LEN_W'(M_LEN_3): sel_base = ADDRESS'(BASE_3);
            LEN_W'(M_LEN_4): sel_base = ADDRESS'(BASE_4);
            default:         sel_ok   = 1'b0;
        endcase
    end

`ifdef BLK_ADDR_SCHED_STALL_EN
    assign advance = addr_rdy;
`else
    assign advance = 1'b1;
`endif

    assign at_last    = (cnt == len_q - LEN_W'(1));
    assign addr_vld   = (state == ST_RUN);
    assign addr_first = addr_vld && (cnt == '0);
    assign addr_last  = addr_vld && at_last;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (arb_any) state_nxt = sel_ok ? ST_LOAD : ST_GAP;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (advance && at_last) state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt == 2'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            err     <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            len_q   <= '0;
            base_q  <= '0;
            cnt     <= '0;
            addr    <= '0;
            gap_cnt <= '0;
        end else begin
            gnt <= '0;
            err <= 1'b0;
            case (state)
                ST_IDLE: if (arb_any) begin
                    gnt     <= arb_onehot;
                    err     <= !sel_ok;
                    owner   <= arb_idx;
                    ptr     <= (arb_idx == 2'(NUM_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;
                    len_q   <= sel_len;
                    base_q  <= sel_base;
                    gap_cnt <= GAP_LD;
                end
                ST_LOAD: begin
                    cnt  <= '0;
                    addr <= base_q;
                end
                ST_RUN: if (advance) begin
                    if (at_last) begin
                        gap_cnt <= GAP_LD;
                    end else begin
                        cnt  <= cnt + LEN_W'(1);
                        addr <= addr + ADDRESS'(1);
                    end
                end
                ST_GAP: if (gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_addr_sched.sv
// Directed bench for blk_addr_sched (NUM_REQ=2, GAP=1); stall section only
// when BLK_ADDR_SCHED_STALL_EN is defined.
module tb_blk_addr_sched;
    localparam int NR = 2;
    localparam int LW = 13;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]   gnt;
    logic            err;
    logic [AW-1:0]   addr;
    logic            addr_vld, addr_first, addr_last, busy;
    logic [1:0]      owner;
`ifdef BLK_ADDR_SCHED_STALL_EN
    logic            addr_rdy = 1'b1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    blk_addr_sched #(.NUM_REQ(NR), .ADDRESS(AW), .LEN_W(LW), .GAP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
`ifdef BLK_ADDR_SCHED_STALL_EN
        .addr_rdy   (addr_rdy),
`endif
        .gnt        (gnt),
        .err        (err),
        .addr       (addr),
        .addr_vld   (addr_vld),
        .addr_first (addr_first),
        .addr_last  (addr_last),
        .owner      (owner),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_vld"}, 32'(addr_vld), 0);
        chk({tag, "_first"}, 32'(addr_first), 0);
        chk({tag, "_last"}, 32'(addr_last), 0);
        chk({tag, "_owner"}, 32'(owner), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge of the gnt cycle; checks the whole sweep, the
    // GAP cycle and the following IDLE cycle. Optionally raises late_req.
    task automatic run_sweep(input int base, input int len, input int own,
                             input int late_at, input logic [NR-1:0] late_req);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk("sw_vld", 32'(addr_vld), 1);
            chk("sw_addr", 32'(addr), 32'(base + k));
            chk("sw_first", 32'(addr_first), 32'(k == 0));
            chk("sw_last", 32'(addr_last), 32'(k == len - 1));
            chk("sw_owner", 32'(owner), 32'(own));
            chk("sw_gnt", 32'(gnt), 0);
            if (k == late_at) req = late_req;
        end
        @(negedge clk);
        chk("gap_vld", 32'(addr_vld), 0);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_last", 32'(addr_last), 0);
        chk("gap_addr_hold", 32'(addr), 32'(base + len - 1));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_gnt", 32'(gnt), 0);
    endtask

    task automatic expect_gnt(input string tag, input logic [NR-1:0] g, input int own, input logic e);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_owner"}, 32'(owner), 32'(own));
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_vld"}, 32'(addr_vld), 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_len = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // single request
        @(negedge clk);
        req_len[0 +: LW] = 13'h120;
        req = 2'b01;
        expect_gnt("single", 2'b01, 0, 1'b0);
        req = '0;
        run_sweep(16'h0000, 16'h120, 0, -1, '0);

        // fairness, pointer restarted at 0
        do_reset();
        req_len[0 +: LW] = 13'h2a0;
        req_len[LW +: LW] = 13'h420;
        req = 2'b11;
        expect_gnt("fair0", 2'b01, 0, 1'b0);
        run_sweep(16'h0120, 16'h2a0, 0, -1, 2'b11);
        expect_gnt("fair1", 2'b10, 1, 1'b0);
        run_sweep(16'h03c0, 16'h420, 1, -1, 2'b11);
        expect_gnt("fair2", 2'b01, 0, 1'b0);

        // unsupported lengths advance the pointer without a sweep
        do_reset();
        req_len[LW +: LW] = 13'h100;
        req = 2'b10;
        expect_gnt("unsup1", 2'b10, 1, 1'b1);
        req = '0;
        @(negedge clk);
        chk("unsup1_busy_end", 32'(busy), 0);
        chk("unsup1_vld", 32'(addr_vld), 0);
        chk("unsup1_err_clr", 32'(err), 0);
        req_len[0 +: LW] = 13'h7ff;
        req = 2'b01;
        expect_gnt("unsup0", 2'b01, 0, 1'b1);
        req = '0;
        @(negedge clk);
        chk("unsup0_busy_end", 32'(busy), 0);
        req_len[0 +: LW] = 13'h120;
        req_len[LW +: LW] = 13'h1b0;
        req = 2'b11;
        expect_gnt("ptr_adv", 2'b10, 1, 1'b0);
        req = '0;
        run_sweep(16'h07e0, 16'h1b0, 1, -1, '0);

        // late request waits for IDLE
        do_reset();
        req_len[0 +: LW] = 13'h120;
        req_len[LW +: LW] = 13'h2a0;
        req = 2'b01;
        expect_gnt("late0", 2'b01, 0, 1'b0);
        req = '0;
        run_sweep(16'h0000, 16'h120, 0, 50, 2'b10);
        expect_gnt("late1", 2'b10, 1, 1'b0);

        // reset mid-sweep
        do_reset();
        req_len[0 +: LW] = 13'h750;
        req = 2'b01;
        expect_gnt("rst_mid", 2'b01, 0, 1'b0);
        req = '0;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            chk("rm_addr", 32'(addr), 32'(16'h0990 + k));
            chk("rm_last", 32'(addr_last), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rm_after");
        rst = 1'b0;
        req_len[0 +: LW] = 13'h120;
        req_len[LW +: LW] = 13'h120;
        req = 2'b11;
        expect_gnt("rm_ptr0", 2'b01, 0, 1'b0);
        req = '0;

`ifdef BLK_ADDR_SCHED_STALL_EN
        begin
            int exp_a;
            int acc;
            int guard;
            do_reset();
            req_len[0 +: LW] = 13'h1b0;
            req = 2'b01;
            expect_gnt("stall", 2'b01, 0, 1'b0);
            req = '0;
            exp_a = 16'h07e0;
            acc = 0;
            guard = 0;
            addr_rdy = 1'b1;
            while (acc < 16'h1b0 && guard < 2000) begin
                @(negedge clk);
                guard++;
                chk("st_vld", 32'(addr_vld), 1);
                chk("st_addr", 32'(addr), 32'(exp_a));
                chk("st_first", 32'(addr_first), 32'(acc == 0));
                chk("st_last", 32'(addr_last), 32'(acc == 16'h1b0 - 1));
                if (addr_rdy) begin
                    acc++;
                    exp_a++;
                end
                addr_rdy = ~addr_rdy;
            end
            chk("st_guard", 32'(guard < 2000), 1);
            addr_rdy = 1'b1;
            @(negedge clk);
            chk("st_gap_vld", 32'(addr_vld), 0);
            chk("st_gap_addr", 32'(addr), 32'h098f);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blk_addr_sched.md
Name: blk_addr_sched

Overview:
- Scheduler for the turbo-block address sweep. Shares one address generator between NUM_REQ requesters (encoder write side, decoder read side, ...).
- Arbitrates round-robin and decodes each request's m_len into a link-ID base address.
- Emits one contiguous address sweep base..base+len-1 per grant, with framing flags.
- Sits between block-level control and the interleaver/buffer memory address port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDRESS, 16, address width.
- LEN_W, 13, m_len width.
- GAP, 1, idle cycles forced between consecutive sweeps (0..3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_len  in  NUM_REQ*LEN_W  per-requester m_len; slice i = bits [i*LEN_W +: LEN_W].
- gnt  out  NUM_REQ  one-hot accept pulse, 1 cycle.
- err  out  1  pulses with gnt when the granted m_len is unsupported.
- addr  out  ADDRESS  sweep address.
- addr_vld  out  1  addr valid.
- addr_first  out  1  first address of sweep.
- addr_last  out  1  last address of sweep.
- owner  out  2  index of the requester owning the current sweep.
- busy  out  1  high from grant through end of GAP.

Behaviour:
- Reset values: all outputs 0; RR pointer 0; state IDLE. Reset mid-sweep aborts the sweep immediately; no addr_last is issued.
- Supported m_len / base (decided):
  - 0x120 -> 0x0000
  - 0x2a0 -> 0x0120
  - 0x420 -> 0x03c0
  - 0x1b0 -> 0x07e0
  - 0x750 -> 0x0990
  - Any other value is unsupported.
- Request rule: requester holds req=1 with stable req_len until it sees its gnt bit. A req dropped before grant is legal and simply ignored.
- FSM states: IDLE, LOAD, RUN, GAP.
  - IDLE: if any req, pick winner by round-robin, starting search at pointer. Register gnt[winner]=1, latch len/base/owner, set pointer=winner+1 mod NUM_REQ, go to LOAD.
  - IDLE, unsupported len: same, plus err=1. Go to GAP (no sweep, owner still updated).
  - LOAD: gnt cleared; cnt=0; go to RUN.
  - RUN: addr_vld=1; addr=base+cnt (ADDRESS-bit add, no overflow for the table). addr_first when cnt==0, addr_last when cnt==len-1. After last, go to GAP, or to IDLE if GAP==0.
  - GAP: addr_vld=0, busy=1 for GAP cycles, then IDLE.
- Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> first addr_vld at cycle 2. Sweep length is exactly len cycles.
- New requests during LOAD/RUN/GAP are not sampled. Arbitration occurs only in IDLE.
- busy = (state != IDLE).
- addr holds its last value when addr_vld=0; addr is 0 after reset.

Optional Feature:
- Macro: BLK_ADDR_SCHED_STALL_EN.
- Defined: adds input addr_rdy (1 bit). In RUN, cnt and addr advance only when addr_vld&&addr_rdy. addr/flags hold stable while addr_rdy=0. The sweep takes len + stall cycles.
- Undefined: no addr_rdy port; sweep advances every RUN cycle.

Decomposition:
- Package blk_addr_pkg holds:
  - the five m_len constants and five base constants;
  - the state encoding (IDLE=0, LOAD=1, RUN=2, GAP=3);
  - LEN_W/ADDRESS defaults.
- One sub-module, rr_arb: combinational round-robin pick from req and pointer, returning one-hot and index. Its own tests cover NUM_REQ=2..4.

Test Plan:
- Single request: req[0]=1, len 0x120 -> gnt[0] at cycle 1. addr 0x0000..0x011f with addr_vld at cycles 2..289; first on 0x0000, last on 0x011f; busy drops after 1 GAP cycle.
- Fairness: req[0] and req[1] both held, lens 0x2a0/0x420 -> grants alternate 0,1,0. Sweeps 0x0120..0x03bf and 0x03c0..0x07df; owner matches.
- Unsupported len: req[1]=1, len 0x0100 -> gnt[1] and err=1 same cycle, no addr_vld, busy high for GAP cycles, pointer advanced.
- Late request: req[1] rises mid-sweep of req[0] -> not granted until IDLE after GAP. gnt[1] arrives 1 cycle after return to IDLE.
- Reset mid-sweep: rst=1 during RUN at cnt=100, len 0x750 -> next cycle all outputs 0, state IDLE, pointer 0, no addr_last.
- STALL_EN: len 0x1b0, addr_rdy toggling 1/0 -> addresses 0x07e0..0x098f each accepted once, held during stalls, sweep length 0x1b0 accepted beats.
